// File: rtl/fft_bram_pkg.sv
// Shared constants, FSM encoding and address layout for the FFT result BRAM.
// Imported by both the write controller and the read-back streamer.
package fft_bram_pkg;

    localparam int NUM_CH   = 8;
    localparam int NUM_BINS = 256;
    localparam int SAMPLE_W = 24;
    localparam int DEPTH    = 2048;
    localparam int ADDR_W   = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        SEND,
        DONE
    } state_t;

    // Word for (bin b, channel c) lives at b*NUM_CH + c.
    function automatic logic [ADDR_W-1:0] addr(input int unsigned b, input int unsigned c);
        return ADDR_W'(b * NUM_CH + c);
    endfunction

endpackage

// File: rtl/fft_bram_reader_if.sv
// BRAM read port plus AXI4-Stream master bundle used by fft_bram_reader.
interface fft_bram_reader_if #(
    parameter int NUM_CH   = fft_bram_pkg::NUM_CH,
    parameter int SAMPLE_W = fft_bram_pkg::SAMPLE_W
);

    logic [31:0]                  bram_addr;
    logic                         bram_en;
    logic                         bram_rst;
    logic [31:0]                  bram_dout_re;
    logic [31:0]                  bram_dout_im;
    logic [NUM_CH*2*SAMPLE_W-1:0] m_axis_tdata;
    logic                         m_axis_tvalid;
    logic                         m_axis_tlast;
    logic                         m_axis_tready;

    modport master (
        output bram_addr, bram_en, bram_rst,
        input  bram_dout_re, bram_dout_im,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  bram_addr, bram_en, bram_rst,
        output bram_dout_re, bram_dout_im,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );

endinterface

// File: rtl/fft_bram_rd_pipe.sv
// Delay line matching the BRAM read latency: carries the issue strobe and the
// channel index so returning data can be steered into the right beat field.
module fft_bram_rd_pipe #(
    parameter int RD_LAT = 2,
    parameter int CH_W   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_vld,
    input  logic [CH_W-1:0] in_ch,
    output logic            out_vld,
    output logic [CH_W-1:0] out_ch
);

    logic [RD_LAT-1:0] vld_sr;
    logic [CH_W-1:0]   ch_sr [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) ch_sr[i] <= '0;
        end else begin
            vld_sr[0] <= in_vld;
            ch_sr[0]  <= in_ch;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                ch_sr[i]  <= ch_sr[i-1];
            end
        end
    end

    assign out_vld = vld_sr[RD_LAT-1];
    assign out_ch  = ch_sr[RD_LAT-1];

endmodule

// File: rtl/fft_bram_reader.sv
// Streams one stored FFT frame out of the result BRAM as AXI4-Stream beats,
// one beat per bin with all channels packed side by side.
module fft_bram_reader
    import fft_bram_pkg::*;
#(
    parameter int NUM_CH   = fft_bram_pkg::NUM_CH,
    parameter int NUM_BINS = fft_bram_pkg::NUM_BINS,
    parameter int SAMPLE_W = fft_bram_pkg::SAMPLE_W,
    parameter int RD_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    fft_bram_reader_if.master bus
);

    localparam int CH_W    = $clog2(NUM_CH);
    localparam int BIN_W   = $clog2(NUM_BINS);
    localparam int CNT_W   = $clog2(NUM_CH + 1);
    localparam int FIELD_W = 2 * SAMPLE_W;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(NUM_BINS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_CH);

    state_t                      state_q, state_d;
    logic [BIN_W-1:0]            bin_q;
    logic [CH_W-1:0]             ch_q;
    logic [CNT_W-1:0]            cap_cnt_q;
    logic [NUM_CH*FIELD_W-1:0]   beat_q;
    logic                        issue_en;
    logic                        tvalid;
    logic                        cap_vld;
    logic [CH_W-1:0]             cap_ch;
    logic                        cap_full;
    logic                        unused_dout_hi;

    fft_bram_rd_pipe #(
        .RD_LAT (RD_LAT),
        .CH_W   (CH_W)
    ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (issue_en),
        .in_ch   (ch_q),
        .out_vld (cap_vld),
        .out_ch  (cap_ch)
    );

    // Count the capture landing this cycle so SEND follows the last word directly.
    assign cap_full = (cap_cnt_q + CNT_W'(cap_vld)) == CNT_FULL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        tvalid   = 1'b0;
        issue_en = 1'b0;
        unique case (state_q)
            IDLE:  if (start) state_d = ISSUE;
            ISSUE: begin
                busy     = 1'b1;
                issue_en = 1'b1;
                if (ch_q == CH_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (cap_full) state_d = SEND;
            end
            SEND: begin
                busy   = 1'b1;
                tvalid = 1'b1;
                if (bus.m_axis_tready) state_d = (bin_q == BIN_LAST) ? DONE : ISSUE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q     <= '0;
            ch_q      <= '0;
            cap_cnt_q <= '0;
            beat_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    bin_q     <= '0;
                    ch_q      <= '0;
                    cap_cnt_q <= '0;
                end
                ISSUE: ch_q <= (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
                SEND: if (bus.m_axis_tready && bin_q != BIN_LAST) begin
                    bin_q     <= bin_q + BIN_W'(1);
                    cap_cnt_q <= '0;
                end
                default: ;
            endcase
            if (cap_vld) begin
                beat_q[32'(cap_ch) * FIELD_W +: SAMPLE_W]            <= bus.bram_dout_re[SAMPLE_W-1:0];
                beat_q[32'(cap_ch) * FIELD_W + SAMPLE_W +: SAMPLE_W] <= bus.bram_dout_im[SAMPLE_W-1:0];
                cap_cnt_q <= cap_cnt_q + CNT_W'(1);
            end
        end
    end

    // Stored words are sign-extended, so the upper bits carry no information.
    assign unused_dout_hi = ^{bus.bram_dout_re[31:SAMPLE_W], bus.bram_dout_im[31:SAMPLE_W]};

    assign bus.bram_addr     = 32'(addr(32'(bin_q), 32'(ch_q)));
    assign bus.bram_en       = issue_en;
    assign bus.bram_rst      = ~rst_n;
    assign bus.m_axis_tdata  = beat_q;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tlast  = tvalid && (bin_q == BIN_LAST);

endmodule

// File: tb/tb_fft_bram_reader.sv
// Directed bench for fft_bram_reader: three instances at RD_LAT 1/2/4 share a
// BRAM image; per-instance monitors score every beat against that image.
module tb_fft_bram_reader;

    localparam int NCH = 8;
    localparam int NB  = 256;
    localparam int SW  = 24;
    localparam int TW  = NCH * 2 * SW;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v = '0;
    logic       tready = 1'b0;
    logic       mon_clr = 1'b1;
    int         rdy_mode = 0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic [31:0] mem_re [2048];
    logic [31:0] mem_im [2048];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // tready changes 1 time unit after each rising edge: 0 low, 1 high, 2 random.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 2) tready = 1'($urandom_range(0, 1));
        else               tready = (rdy_mode == 1);
    end

    function automatic logic [TW-1:0] exp_beat(input int b);
        logic [TW-1:0] r;
        for (int c = 0; c < NCH; c++) begin
            r[48*c +: 24]      = mem_re[b*NCH + c][23:0];
            r[48*c + 24 +: 24] = mem_im[b*NCH + c][23:0];
        end
        return r;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);

        fft_bram_reader_if #(.NUM_CH(NCH), .SAMPLE_W(SW)) bus ();
        logic busy, done;
        logic [31:0] pre_re [LAT];
        logic [31:0] pre_im [LAT];

        fft_bram_reader #(
            .NUM_CH(NCH), .NUM_BINS(NB), .SAMPLE_W(SW), .RD_LAT(LAT)
        ) dut (
            .clk(clk), .rst_n(rst_n), .start(start_v[gi]),
            .busy(busy), .done(done), .bus(bus)
        );

        assign bus.m_axis_tready = tready;

        // BRAM read port with LAT cycles of latency; garbage when not enabled.
        always @(posedge clk) begin
            pre_re[0] <= bus.bram_en ? mem_re[bus.bram_addr[10:0]] : 32'hDEADBEEF;
            pre_im[0] <= bus.bram_en ? mem_im[bus.bram_addr[10:0]] : 32'hDEADBEEF;
            for (int k = 1; k < LAT; k++) begin
                pre_re[k] <= pre_re[k-1];
                pre_im[k] <= pre_im[k-1];
            end
        end
        assign bus.bram_dout_re = pre_re[LAT-1];
        assign bus.bram_dout_im = pre_im[LAT-1];

        int beats, data_err, last_err, stab_err, en_err, done_cnt, busy_err;
        int first_vld, done_cyc, stall_cnt;
        int hs_cyc [NB];
        logic [TW-1:0] cap [NB];
        logic prev_stall, prev_last;
        logic [TW-1:0] prev_data;

        always @(negedge clk) begin
            if (mon_clr) begin
                beats = 0; data_err = 0; last_err = 0; stab_err = 0; en_err = 0;
                done_cnt = 0; busy_err = 0; first_vld = -1; done_cyc = -1;
                stall_cnt = 0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
            end else begin
                if (prev_stall && (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== prev_data
                                   || bus.m_axis_tlast !== prev_last))
                    stab_err++;
                if (bus.m_axis_tvalid && !bus.m_axis_tready) begin
                    stall_cnt++;
                    if (bus.bram_en !== 1'b0) en_err++;
                end
                if (bus.m_axis_tvalid && first_vld < 0) first_vld = cyc;
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    if (beats < NB) begin
                        cap[beats]    = bus.m_axis_tdata;
                        hs_cyc[beats] = cyc;
                        if (bus.m_axis_tdata !== exp_beat(beats)) data_err++;
                        if (bus.m_axis_tlast !== (beats == NB - 1)) last_err++;
                    end else begin
                        data_err++;
                    end
                    beats++;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (busy !== 1'b0) busy_err++;
                end
                prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
                prev_data  = bus.m_axis_tdata;
                prev_last  = bus.m_axis_tlast;
            end
        end
    end

    task automatic fill_mem();
        for (int a = 0; a < 2048; a++) begin
            mem_re[a] = 32'(a);
            mem_im[a] = 32'(0 - a);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start(input logic [2:0] m, output int t);
        @(posedge clk); #1 start_v = m; t = cyc;
        @(posedge clk); #1 start_v = '0;
    endtask

    task automatic wait_done(input logic [2:0] m, input int budget, input string tag);
        int n = 0;
        while (!((!m[0] || g[0].done_cnt > 0) && (!m[1] || g[1].done_cnt > 0)
                 && (!m[2] || g[2].done_cnt > 0)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL %s_timeout: no done within %0d cycles, required done", tag, n);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (g[1].bus.bram_addr !== 32'd0 || g[1].bus.bram_en !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_bram: addr=%h en=%b, required 0/0", g[1].bus.bram_addr, g[1].bus.bram_en);
        end
        n_cmp++;
        if (g[1].bus.m_axis_tdata !== '0 || g[1].bus.m_axis_tvalid !== 1'b0 || g[1].bus.m_axis_tlast !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_axis: tvalid=%b tlast=%b tdata_nonzero=%b, required 0/0/0",
                     g[1].bus.m_axis_tvalid, g[1].bus.m_axis_tlast, |g[1].bus.m_axis_tdata);
        end
        n_cmp++;
        if (g[1].busy !== 1'b0 || g[1].done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_status: busy=%b done=%b, required 0/0", g[1].busy, g[1].done);
        end
        n_cmp++;
        if (g[1].bus.bram_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_bram_rst: got %b, required 1", g[1].bus.bram_rst);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        clear_mon();
    endtask

    task automatic test_frame();
        int t;
        rdy_mode = 1;
        clear_mon();
        pulse_start(3'b010, t);
        @(negedge clk);
        n_cmp++;
        if (g[1].bus.bram_en !== 1'b1 || g[1].bus.bram_addr !== 32'd0 || g[1].busy !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_first_issue: en=%b addr=%h busy=%b, required 1/0/1",
                     g[1].bus.bram_en, g[1].bus.bram_addr, g[1].busy);
        end
        wait_done(3'b010, 3500, "frame");
        n_cmp++;
        if (g[1].beats != 256 || g[1].data_err != 0) begin
            n_bad++;
            $display("FAIL frame_data: beats=%0d bad=%0d, required 256/0", g[1].beats, g[1].data_err);
        end
        n_cmp++;
        if (g[1].last_err != 0) begin
            n_bad++;
            $display("FAIL frame_tlast: misplaced tlast on %0d beats, required 0", g[1].last_err);
        end
        n_cmp++;
        if (g[1].cap[1][47:0] !== 48'hFFFFF8_000008) begin
            n_bad++;
            $display("FAIL frame_bin1_ch0: got %h, required fffff8000008", g[1].cap[1][47:0]);
        end
        n_cmp++;
        if (g[1].cap[255][383:336] !== 48'hFFF801_0007FF) begin
            n_bad++;
            $display("FAIL frame_bin255_ch7: got %h, required fff8010007ff", g[1].cap[255][383:336]);
        end
        n_cmp++;
        if (g[1].done_cnt != 1 || g[1].busy_err != 0) begin
            n_bad++;
            $display("FAIL frame_done: pulses=%0d busy_at_done=%0d, required 1/0", g[1].done_cnt, g[1].busy_err);
        end
        n_cmp++;
        if (g[1].done_cyc - g[1].hs_cyc[255] != 1) begin
            n_bad++;
            $display("FAIL frame_done_latency: got %0d, required 1", g[1].done_cyc - g[1].hs_cyc[255]);
        end
        n_cmp++;
        if (g[1].first_vld - t != 11) begin
            n_bad++;
            $display("FAIL frame_first_valid: got T+%0d, required T+11", g[1].first_vld - t);
        end
        n_cmp++;
        if (g[1].hs_cyc[255] - g[1].hs_cyc[0] != 2805) begin
            n_bad++;
            $display("FAIL frame_length: got %0d, required 2805", g[1].hs_cyc[255] - g[1].hs_cyc[0]);
        end
    endtask

    task automatic test_latency();
        int t;
        rdy_mode = 1;
        clear_mon();
        pulse_start(3'b111, t);
        wait_done(3'b111, 3500, "latency");
        n_cmp++;
        if (g[0].first_vld - t != 10 || g[0].hs_cyc[1] - g[0].hs_cyc[0] != 10) begin
            n_bad++;
            $display("FAIL lat1_timing: first=T+%0d spacing=%0d, required 10/10",
                     g[0].first_vld - t, g[0].hs_cyc[1] - g[0].hs_cyc[0]);
        end
        n_cmp++;
        if (g[1].first_vld - t != 11 || g[1].hs_cyc[1] - g[1].hs_cyc[0] != 11) begin
            n_bad++;
            $display("FAIL lat2_timing: first=T+%0d spacing=%0d, required 11/11",
                     g[1].first_vld - t, g[1].hs_cyc[1] - g[1].hs_cyc[0]);
        end
        n_cmp++;
        if (g[2].first_vld - t != 13 || g[2].hs_cyc[1] - g[2].hs_cyc[0] != 13) begin
            n_bad++;
            $display("FAIL lat4_timing: first=T+%0d spacing=%0d, required 13/13",
                     g[2].first_vld - t, g[2].hs_cyc[1] - g[2].hs_cyc[0]);
        end
        n_cmp++;
        if (g[0].beats != 256 || g[0].data_err != 0 || g[2].beats != 256 || g[2].data_err != 0) begin
            n_bad++;
            $display("FAIL latency_data: lat1 beats=%0d bad=%0d lat4 beats=%0d bad=%0d, required 256/0",
                     g[0].beats, g[0].data_err, g[2].beats, g[2].data_err);
        end
    endtask

    task automatic test_stall();
        int t;
        rdy_mode = 2;
        clear_mon();
        pulse_start(3'b010, t);
        wait_done(3'b010, 12000, "stall");
        rdy_mode = 1;
        n_cmp++;
        if (g[1].beats != 256 || g[1].data_err != 0 || g[1].last_err != 0) begin
            n_bad++;
            $display("FAIL stall_data: beats=%0d bad=%0d tlast_bad=%0d, required 256/0/0",
                     g[1].beats, g[1].data_err, g[1].last_err);
        end
        n_cmp++;
        if (g[1].stab_err != 0) begin
            n_bad++;
            $display("FAIL stall_hold: %0d unstable stall cycles, required 0", g[1].stab_err);
        end
        n_cmp++;
        if (g[1].en_err != 0) begin
            n_bad++;
            $display("FAIL stall_bram_en: %0d reads during stall, required 0", g[1].en_err);
        end
        n_cmp++;
        if (g[1].stall_cnt < 50 || g[1].done_cnt != 1) begin
            n_bad++;
            $display("FAIL stall_coverage: stalls=%0d done=%0d, required >=50/1", g[1].stall_cnt, g[1].done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        int t, t2, n;
        rdy_mode = 1;
        clear_mon();
        pulse_start(3'b010, t);
        repeat (30) @(posedge clk);
        pulse_start(3'b010, t2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(g[1].bus.m_axis_tvalid && g[1].bus.m_axis_tlast && g[1].bus.m_axis_tready) && n < 4000);
        n_cmp++;
        if (n >= 4000) begin
            n_bad++;
            $display("FAIL ignore_timeout: no final beat within %0d cycles, required final beat", n);
        end
        @(posedge clk); #1 start_v = 3'b010;
        @(negedge clk);
        n_cmp++;
        if (g[1].done !== 1'b1) begin
            n_bad++;
            $display("FAIL ignore_done_cycle: done=%b, required 1", g[1].done);
        end
        @(posedge clk); #1 start_v = '0;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (g[1].busy !== 1'b0 || g[1].bus.m_axis_tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_idle: busy=%b tvalid=%b, required 0/0", g[1].busy, g[1].bus.m_axis_tvalid);
        end
        n_cmp++;
        if (g[1].beats != 256 || g[1].data_err != 0 || g[1].done_cnt != 1) begin
            n_bad++;
            $display("FAIL ignore_one_frame: beats=%0d bad=%0d done=%0d, required 256/0/1",
                     g[1].beats, g[1].data_err, g[1].done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int t, n;
        rdy_mode = 1;
        clear_mon();
        pulse_start(3'b010, t);
        n = 0;
        while (g[1].beats < 100 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        rdy_mode = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (g[1].bus.m_axis_tvalid !== 1'b1 && n < 50);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (g[1].bus.m_axis_tvalid !== 1'b1 || g[1].beats != 100) begin
            n_bad++;
            $display("FAIL rstmid_stalled: tvalid=%b beats=%0d, required 1/100", g[1].bus.m_axis_tvalid, g[1].beats);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (g[1].bus.m_axis_tvalid !== 1'b0 || g[1].bus.m_axis_tlast !== 1'b0 || g[1].bus.m_axis_tdata !== '0) begin
            n_bad++;
            $display("FAIL rstmid_axis: tvalid=%b tlast=%b tdata_nonzero=%b, required 0/0/0",
                     g[1].bus.m_axis_tvalid, g[1].bus.m_axis_tlast, |g[1].bus.m_axis_tdata);
        end
        n_cmp++;
        if (g[1].busy !== 1'b0 || g[1].done !== 1'b0 || g[1].bus.bram_en !== 1'b0 || g[1].bus.bram_addr !== 32'd0) begin
            n_bad++;
            $display("FAIL rstmid_ctrl: busy=%b done=%b en=%b addr=%h, required 0/0/0/0",
                     g[1].busy, g[1].done, g[1].bus.bram_en, g[1].bus.bram_addr);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        rdy_mode = 1;
        clear_mon();
        pulse_start(3'b010, t);
        wait_done(3'b010, 3500, "rstmid");
        n_cmp++;
        if (g[1].beats != 256 || g[1].data_err != 0 || g[1].done_cnt != 1) begin
            n_bad++;
            $display("FAIL rstmid_replay: beats=%0d bad=%0d done=%0d, required 256/0/1",
                     g[1].beats, g[1].data_err, g[1].done_cnt);
        end
        n_cmp++;
        if (g[1].cap[0][95:48] !== 48'hFFFFFF_000001) begin
            n_bad++;
            $display("FAIL rstmid_bin0_ch1: got %h, required ffffff000001", g[1].cap[0][95:48]);
        end
    endtask

    task automatic test_saturate();
        int t;
        mem_re[3*NCH + 5] = 32'h007FFFFF;
        mem_im[3*NCH + 5] = 32'hFF800000;
        rdy_mode = 1;
        clear_mon();
        pulse_start(3'b010, t);
        wait_done(3'b010, 3500, "saturate");
        n_cmp++;
        if (g[1].cap[3][5*48 +: 24] !== 24'h7FFFFF) begin
            n_bad++;
            $display("FAIL sat_re: got %h, required 7fffff", g[1].cap[3][5*48 +: 24]);
        end
        n_cmp++;
        if (g[1].cap[3][5*48 + 24 +: 24] !== 24'h800000) begin
            n_bad++;
            $display("FAIL sat_im: got %h, required 800000", g[1].cap[3][5*48 + 24 +: 24]);
        end
        n_cmp++;
        if (g[1].beats != 256 || g[1].data_err != 0) begin
            n_bad++;
            $display("FAIL sat_frame: beats=%0d bad=%0d, required 256/0", g[1].beats, g[1].data_err);
        end
    endtask

    initial begin
        fill_mem();
        test_reset();
        test_frame();
        test_latency();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_bram_reader.md
# fft_bram_reader

Reads one complete FFT frame back out of the FFT result BRAM through its read port and replays it as an AXI4-Stream. It emits one 384-bit beat per frequency bin, with all 8 microphone channels packed into each beat. It is the read-side counterpart of the FFT-to-BRAM write controller and shares the same address layout and data packing, so a stored frame can be streamed to downstream beamforming or DMA logic.

## Interface
Parameters:
- NUM_CH, 8, microphone channels per bin.
- NUM_BINS, 256, FFT bins per frame.
- SAMPLE_W, 24, width of each real and each imaginary sample on the stream.
- RD_LAT, 2, BRAM read latency in cycles, from address/enable to valid dout. Legal values are 1 to 4.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a frame readout. Ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last beat is accepted.
- bram_addr  out  32  word address, zero-extended from 11 bits.
- bram_en  out  1  read enable. High only on issue cycles.
- bram_rst  out  1  equals ~rst_n.
- bram_dout_re  in  32  real word read from BRAM.
- bram_dout_im  in  32  imaginary word read from BRAM.
- m_axis_tdata  out  NUM_CH*2*SAMPLE_W (384)  packed bin data.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tlast  out  1  high on the bin NUM_BINS-1 beat.
- m_axis_tready  in  1  downstream ready.

## Operation
- BRAM layout: the word for (bin b, channel c) is at address b*NUM_CH + c. The depth is 2048.
- Packing: channel c occupies bits [2*SAMPLE_W*c +: 2*SAMPLE_W].
  - The real sample is in the lower SAMPLE_W bits of that field.
  - The imaginary sample is in the upper SAMPLE_W bits.
  - Each sample is bits [SAMPLE_W-1:0] of the corresponding BRAM word. Stored words are sign-extended, so this truncation is lossless.
- State machine states: IDLE, ISSUE, DRAIN, SEND, DONE.
- IDLE:
  - Outputs: busy=0, tvalid=0.
  - A start pulse clears the bin counter and moves to ISSUE.
- ISSUE:
  - Each cycle asserts bram_en and sets bram_addr to bin*NUM_CH + ch, with ch counting from 0 to NUM_CH-1.
  - After ch=NUM_CH-1 the FSM moves to DRAIN.
- Capture pipeline:
  - A valid/channel-index shift register of depth RD_LAT delays each issued channel index.
  - When the delayed valid is high, bram_dout_re and bram_dout_im are written into that channel's field of the beat register.
- DRAIN: waits until the capture count reaches NUM_CH, then moves to SEND.
- SEND:
  - tvalid=1. tdata and tlast are held stable until tready=1.
  - On the handshake, if bin==NUM_BINS-1 the FSM moves to DONE. Otherwise bin increments and the FSM moves to ISSUE.
- DONE: pulses done for one cycle and returns to IDLE.
- start is ignored in every state except IDLE, including a start that coincides with the done cycle.
- Reset clears all state asynchronously.
  - tvalid deasserts immediately.
  - A frame interrupted by reset is not resumed.

## Timing
- Reset values: bram_addr=0, bram_en=0, m_axis_tdata=0, tvalid=0, tlast=0, busy=0, done=0.
- The start pulse is seen in cycle T.
  - The first issue happens in cycle T+1.
  - The beat for bin 0 is valid at T+1+NUM_CH+RD_LAT.
- With tready held high, each bin takes NUM_CH+RD_LAT+1 cycles. For the default parameters this is 11 cycles, and a frame takes 2816 cycles.
- tready low stalls the FSM in SEND. No BRAM reads are issued while stalled.
- tready may toggle freely. A beat is transferred only on a cycle where tvalid and tready are both high.
- done is asserted one cycle after the final handshake.
- busy falls in the same cycle that done is asserted.

## Structure
- Package fft_bram_pkg holds:
  - NUM_CH, NUM_BINS, SAMPLE_W and the depth constant;
  - the state encoding;
  - the address function addr(b, c) = b*NUM_CH + c.
- The write controller imports the same package.
- Sub-module fft_bram_rd_pipe: the RD_LAT-deep valid and channel-index delay line. It has ports clk, rst_n, in_vld, in_ch, out_vld, out_ch.

## Test plan
- BRAM model preloaded with re=addr and im=-addr (sign-extended), tready=1, start pulsed:
  - 256 beats are produced;
  - in beat b, channel c has re=8b+c and im=-(8b+c) in 24-bit form;
  - tlast is high only on beat 255, and done pulses once.
- RD_LAT set to 1, 2 and 4:
  - the first tvalid arrives at T+1+8+RD_LAT;
  - bin spacing is 9+RD_LAT cycles;
  - data is identical across all three settings.
- Random tready (50% duty):
  - tdata and tlast are stable while tvalid=1 and tready=0;
  - bram_en=0 during stalls;
  - no beat is lost or duplicated.
- start pulsed while busy, and start pulsed on the done cycle: both are ignored, and exactly one frame is emitted per accepted start.
- rst_n asserted during a stall in bin 100:
  - all outputs return to their reset values immediately;
  - a new start then replays the frame from bin 0.
- Saturating BRAM words are read: re=0x007FFFFF and im=0xFF800000 pack as 0x7FFFFF and 0x800000 in that channel's 24-bit fields.
